// File: rtl/wib_sram2p_buf.sv
// WIB simple dual-port buffer: byte-enabled write, credit-controlled read path, zero-fill engine.
// Optional macro WIB_SRAM_BYPASS_EN: same-cycle read/write collisions return merged data.
module wib_sram2p_buf #(
    parameter int AW   = 10,
    parameter int DW   = 32,
    parameter int OREG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_vld_i,
    output logic            wr_rdy_o,
    input  logic [DW/8-1:0] wr_be_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [DW-1:0]   wr_data_i,
    input  logic            rd_vld_i,
    output logic            rd_rdy_o,
    input  logic [AW-1:0]   rd_addr_i,
    output logic            rdo_vld_o,
    input  logic            rdo_rdy_i,
    output logic [DW-1:0]   rdo_data_o,
    input  logic            init_start_i,
    output logic            init_busy_o
);

    localparam int DP = 1 << AW;
    localparam int BW = DW / 8;
    localparam int D  = 2 + OREG;
    localparam int CW = $clog2(D + 1);
    localparam int PW = $clog2(D);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]   cr_q, cr_d;
    logic            wr_acc, rd_acc;
    logic [DW-1:0]   mem [DP];
    logic [DW-1:0]   rd_word;
    logic            m_vld_q;
    logic [DW-1:0]   m_data_q;
    logic            last_vld;
    logic [DW-1:0]   last_data;
    logic [DW-1:0]   fifo_q [D];
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop, fifo_ne, cons;

    assign wr_rdy_o    = (state_q == IDLE);
    assign rd_rdy_o    = (state_q == IDLE) && (cr_q != '0);
    assign init_busy_o = (state_q == CLEAR);
    assign wr_acc      = wr_vld_i && wr_rdy_o;
    assign rd_acc      = rd_vld_i && rd_rdy_o;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (init_start_i) state_d = CLEAR;
            end
            CLEAR: begin
                if (clr_cnt_q == '1) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Array is deliberately not reset; a reset during CLEAR leaves a partial fill.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < BW; i++) begin
                if (wr_be_i[i]) mem[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_addr_i];
`ifdef WIB_SRAM_BYPASS_EN
        if (wr_acc && (wr_addr_i == rd_addr_i)) begin
            for (int i = 0; i < BW; i++) begin
                if (wr_be_i[i]) rd_word[8*i +: 8] = wr_data_i[8*i +: 8];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld_q  <= 1'b0;
            m_data_q <= '0;
        end else begin
            m_vld_q <= rd_acc;
            if (rd_acc) m_data_q <= rd_word;
        end
    end

    if (OREG != 0) begin : g_oreg
        logic          o_vld_q;
        logic [DW-1:0] o_data_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                o_vld_q  <= 1'b0;
                o_data_q <= '0;
            end else begin
                o_vld_q <= m_vld_q;
                if (m_vld_q) o_data_q <= m_data_q;
            end
        end
        assign last_vld  = o_vld_q;
        assign last_data = o_data_q;
    end else begin : g_noreg
        assign last_vld  = m_vld_q;
        assign last_data = m_data_q;
    end

    // Stages free-run; credits bound in-flight reads to D so the FIFO never overflows.
    assign fifo_ne    = (cnt_q != '0);
    assign rdo_vld_o  = fifo_ne || last_vld;
    assign rdo_data_o = fifo_ne ? fifo_q[rptr_q] : last_data;
    assign cons       = rdo_vld_o && rdo_rdy_i;
    assign pop        = fifo_ne && rdo_rdy_i;
    assign push       = last_vld && !(!fifo_ne && rdo_rdy_i);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        cr_d   = cr_q;
        if (push) wptr_d = (wptr_q == PW'(D - 1)) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_d = (rptr_q == PW'(D - 1)) ? '0 : rptr_q + 1'b1;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        if (pop && !push) cnt_d = cnt_q - 1'b1;
        if (cons && !rd_acc) cr_d = cr_q + 1'b1;
        if (rd_acc && !cons) cr_d = cr_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            cr_q   <= CW'(D);
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            cr_q   <= cr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= last_data;
    end

endmodule

// File: tb/tb_wib_sram2p_buf.sv
// Bench for wib_sram2p_buf: vector table, corner sequences and a randomized
// phase scored against a queue/array model of the buffer.
module tb_wib_sram2p_buf;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int OREG = 1;
    localparam int DP   = 1 << AW;
    localparam int BW   = DW / 8;
    localparam int D    = 2 + OREG;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_vld = 1'b0, wr_rdy;
    logic [BW-1:0] wr_be = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_vld = 1'b0, rd_rdy;
    logic [AW-1:0] rd_addr = '0;
    logic          rdo_vld;
    logic          rdo_rdy = 1'b0;
    logic [DW-1:0] rdo_data;
    logic          init_start = 1'b0, init_busy;

    int checks = 0;
    int failures = 0;

    wib_sram2p_buf #(.AW(AW), .DW(DW), .OREG(OREG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_vld_i    (wr_vld),
        .wr_rdy_o    (wr_rdy),
        .wr_be_i     (wr_be),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rd_vld_i    (rd_vld),
        .rd_rdy_o    (rd_rdy),
        .rd_addr_i   (rd_addr),
        .rdo_vld_o   (rdo_vld),
        .rdo_rdy_i   (rdo_rdy),
        .rdo_data_o  (rdo_data),
        .init_start_i(init_start),
        .init_busy_o (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: word array, queue of expected outputs, clear countdown.
    logic [DW-1:0] mdl [DP];
    logic [DW-1:0] expq [$];
    bit            mbusy = 1'b0;
    int            mbusy_cnt = 0;

    always @(negedge clk) begin
        logic [DW-1:0] rw;
        bit racc, wacc;
        if (!rst_n) begin
            expq.delete();
            mbusy = 1'b0;
            mbusy_cnt = 0;
        end else begin
            racc = rd_vld && !mbusy && (expq.size() < D);
            wacc = wr_vld && !mbusy;
            chk("rd_rdy", rd_rdy, (!mbusy && expq.size() < D));
            chk("wr_rdy", wr_rdy, !mbusy);
            chk("init_busy", init_busy, mbusy);
            if (rdo_vld) begin
                if (expq.size() == 0) chk("rdo_spurious", 1'b1, 1'b0);
                else if (rdo_rdy) begin
                    chk("rdo_data", rdo_data, expq[0]);
                    void'(expq.pop_front());
                end
            end
            if (racc) begin
                rw = mdl[rd_addr];
`ifdef WIB_SRAM_BYPASS_EN
                if (wacc && wr_addr == rd_addr)
                    for (int i = 0; i < BW; i++)
                        if (wr_be[i]) rw[8*i +: 8] = wr_data[8*i +: 8];
`endif
                expq.push_back(rw);
            end
            if (wacc)
                for (int i = 0; i < BW; i++)
                    if (wr_be[i]) mdl[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
            if (mbusy) begin
                mbusy_cnt--;
                if (mbusy_cnt == 0) mbusy = 1'b0;
            end else if (init_start) begin
                for (int a = 0; a < DP; a++) mdl[a] = '0;
                mbusy = 1'b1;
                mbusy_cnt = DP;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        int t = 0;
        wr_vld = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        while (!wr_rdy && t < 5000) begin tick(); t++; end
        if (!wr_rdy) chk("wr_timeout", 1'b0, 1'b1);
        tick();
        wr_vld = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int t = 0;
        rdo_rdy = 1'b1; rd_vld = 1'b1; rd_addr = a;
        while (!rd_rdy && t < 5000) begin tick(); t++; end
        if (!rd_rdy) chk({nm, "_timeout"}, 1'b0, 1'b1);
        tick();
        rd_vld = 1'b0;
        chk({nm, "_early"}, rdo_vld, 1'b0);
        tick();
        chk({nm, "_vld"}, rdo_vld, 1'b1);
        chk(nm, rdo_data, exp);
        tick();
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d1;
        logic [BW-1:0] be;
        logic [DW-1:0] d2;
        logic [DW-1:0] exp;
        string         nm;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int k, idx, n, bad, nz, t;
        logic [DW-1:0] col_exp;

        #1000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, idx, n, bad, nz, t;
        logic [DW-1:0] col_exp;

        tbl[0] = '{10'd5,    32'hA1B2C3D4, 4'b0000, 32'hFFFFFFFF, 32'hA1B2C3D4, "v_be0"};
        tbl[1] = '{10'd7,    32'h11223344, 4'b0101, 32'hFFFFFFFF, 32'h11FF33FF, "v_be5"};
        tbl[2] = '{10'd0,    32'h00000000, 4'b1010, 32'hAABBCCDD, 32'hAA00CC00, "v_addr0"};
        tbl[3] = '{10'd1023, 32'h89ABCDEF, 4'b1111, 32'h01234567, 32'h01234567, "v_addrmax"};
        tbl[4] = '{10'd512,  32'hCAFEF00D, 4'b1000, 32'h77665544, 32'h77FEF00D, "v_be8"};

        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_rdo_vld", rdo_vld, 1'b0);
        chk("rst_rdo_data", rdo_data, 32'h0);
        chk("rst_init_busy", init_busy, 1'b0);
        chk("rst_wr_rdy", wr_rdy, 1'b1);
        chk("rst_rd_rdy", rd_rdy, 1'b1);
        tick();

        wr(10'd5, 4'hF, 32'hA1B2C3D4);
        rd_chk("plain_rd", 10'd5, 32'hA1B2C3D4);

        for (int i = 0; i < 5; i++) begin
            wr(tbl[i].a, 4'hF, tbl[i].d1);
            wr(tbl[i].a, tbl[i].be, tbl[i].d2);
            rd_chk(tbl[i].nm, tbl[i].a, tbl[i].exp);
        end

        // Same-cycle read and write to one address.
        wr(10'd3, 4'hF, 32'h12345678);
`ifdef WIB_SRAM_BYPASS_EN
        col_exp = 32'h1234BEEF;
`else
        col_exp = 32'h12345678;
`endif
        rdo_rdy = 1'b1;
        wr_vld = 1'b1; wr_addr = 10'd3; wr_be = 4'b0011; wr_data = 32'hDEADBEEF;
        rd_vld = 1'b1; rd_addr = 10'd3;
        tick();
        wr_vld = 1'b0; rd_vld = 1'b0;
        tick();
        chk("col_vld", rdo_vld, 1'b1);
        chk("col_data", rdo_data, col_exp);
        tick();
        rd_chk("col_after", 10'd3, 32'h1234BEEF);

        // Backpressure: ten reads with the consumer stalled, then random rdo_rdy.
        for (int i = 0; i < 10; i++) wr(AW'(i), 4'hF, DW'(i));
        rdo_rdy = 1'b0;
        k = 0;
        rd_vld = 1'b1; rd_addr = '0;
        for (int c = 0; c < 20; c++) begin
            if (!rd_rdy) break;
            tick();
            k++;
            rd_addr = AW'(k);
        end
        chk("bp_accepts", k, D);
        idx = 0; t = 0;
        while (idx < 10 && t < 500) begin
            rdo_rdy = 1'($urandom_range(0, 1));
            rd_vld = (k < 10);
            rd_addr = AW'(k);
            if (rdo_vld && rdo_rdy) begin
                chk("bp_order", rdo_data, DW'(idx));
                idx++;
            end
            if (rd_vld && rd_rdy) k++;
            tick();
            t++;
        end
        chk("bp_count", idx, 10);
        rd_vld = 1'b0; rdo_rdy = 1'b1;
        repeat (5) tick();
        chk("bp_nodup", rdo_vld, 1'b0);

        // Fill, zero-fill, read back.
        for (int a = 0; a < DP; a++) wr(AW'(a), 4'hF, 32'hA5000000 | DW'(a + 1));
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        n = 0; bad = 0;
        while (init_busy && n < DP + 10) begin
            if (wr_rdy || rd_rdy) bad++;
            n++;
            tick();
        end
        chk("init_len", n, DP);
        chk("init_rdy_low", bad, 0);
        chk("init_done_rdy", rd_rdy, 1'b1);
        rdo_rdy = 1'b1;
        k = 0; idx = 0; nz = 0; t = 0;
        while (idx < DP && t < 3 * DP) begin
            rd_vld = (k < DP);
            rd_addr = AW'(k);
            if (rdo_vld) begin
                if (rdo_data != '0) nz++;
                idx++;
            end
            if (rd_vld && rd_rdy) k++;
            tick();
            t++;
        end
        rd_vld = 1'b0;
        chk("init_rd_count", idx, DP);
        chk("init_nonzero", nz, 0);

        // Random traffic on a small address window to force collisions.
        for (int c = 0; c < 1500; c++) begin
            wr_vld  = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 15));
            wr_be   = BW'($urandom);
            wr_data = $urandom;
            rd_vld  = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom_range(0, 15));
            rdo_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        wr_vld = 1'b0; rd_vld = 1'b0; rdo_rdy = 1'b1;
        repeat (10) tick();
        chk("rand_drain", expq.size(), 0);

        // Reset with two reads in flight.
        rdo_rdy = 1'b0;
        rd_vld = 1'b1; rd_addr = 10'd1;
        tick();
        tick();
        rd_vld = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst2_rdo_vld", rdo_vld, 1'b0);
        chk("rst2_rdo_data", rdo_data, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst2_rd_rdy", rd_rdy, 1'b1);
        chk("rst2_wr_rdy", wr_rdy, 1'b1);
        tick();
        k = 0;
        rd_vld = 1'b1; rd_addr = 10'd2;
        for (int c = 0; c < 10; c++) begin
            if (!rd_rdy) break;
            tick();
            k++;
        end
        chk("rst2_credits", k, D);
        rd_vld = 1'b0; rdo_rdy = 1'b1;
        repeat (8) tick();
        chk("rst2_drain", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
